// File: rtl/bsg_cgol_ctrl.sv
// Game-of-Life board controller: loads an initial board into the cell array,
// enables a bounded number of generations, then presents the result to the host.
module bsg_cgol_ctrl #(
   parameter int unsigned board_width_p     = 8,
   parameter int unsigned max_game_length_p = 1024,
   localparam int unsigned num_cells_lp      = board_width_p * board_width_p,
   localparam int unsigned frame_width_lp    = $clog2(max_game_length_p + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      v_i,
   input  logic [num_cells_lp-1:0]   data_i,
   input  logic [frame_width_lp-1:0] frames_i,
   output logic                      ready_o,
   output logic                      v_o,
   output logic [num_cells_lp-1:0]   data_o,
   input  logic                      yumi_i,
   output logic                      update_o,
   output logic [num_cells_lp-1:0]   update_val_o,
   output logic                      en_o,
   input  logic [num_cells_lp-1:0]   cell_data_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [frame_width_lp-1:0] max_frames_lp = frame_width_lp'(max_game_length_p);

   state_e                    r_state;
   state_e                    w_state_nxt;
   logic [frame_width_lp-1:0] r_cnt;
   logic [frame_width_lp-1:0] w_cnt_nxt;
   logic [num_cells_lp-1:0]   r_board;
   logic [num_cells_lp-1:0]   w_board_nxt;
   logic [frame_width_lp-1:0] w_frames_clamped;

   assign w_frames_clamped = (frames_i > max_frames_lp) ? max_frames_lp : frames_i;
   assign update_val_o     = r_board;
   assign data_o           = cell_data_i;

   // State, frame counter and latched board
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_board <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_board <= w_board_nxt;
      end
   end

   // Next-state and output decode; reset masks every handshake/strobe output
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_board_nxt = r_board;
      ready_o     = 1'b0;
      v_o         = 1'b0;
      update_o    = 1'b0;
      en_o        = 1'b0;
      case (r_state)
         IDLE: begin
            ready_o = 1'b1;
            if (v_i) begin
               w_board_nxt = data_i;
               w_cnt_nxt   = w_frames_clamped;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            update_o    = 1'b1;
            w_state_nxt = (r_cnt != '0) ? RUN : DONE;
         end
         RUN: begin
            en_o      = 1'b1;
            w_cnt_nxt = r_cnt - frame_width_lp'(1);
            if (r_cnt <= frame_width_lp'(1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            v_o = 1'b1;
            if (yumi_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (reset_i) begin
         ready_o  = 1'b0;
         v_o      = 1'b0;
         update_o = 1'b0;
         en_o     = 1'b0;
      end
   end

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Bench for bsg_cgol_ctrl on a 4x4 board driving a behavioral cell array with dead boundary.
module tb_bsg_cgol_ctrl;

   localparam int unsigned bw_lp  = 4;
   localparam int unsigned n_lp   = bw_lp * bw_lp;
   localparam int unsigned max_lp = 1024;
   localparam int unsigned fw_lp  = $clog2(max_lp + 1);

   logic              clk_i = 1'b0;
   logic              reset_i = 1'b1;
   logic              v_i = 1'b0;
   logic [n_lp-1:0]   data_i = '0;
   logic [fw_lp-1:0]  frames_i = '0;
   logic              ready_o;
   logic              v_o;
   logic [n_lp-1:0]   data_o;
   logic              yumi_i = 1'b0;
   logic              update_o;
   logic [n_lp-1:0]   update_val_o;
   logic              en_o;
   logic [n_lp-1:0]   r_cells;

   int total = 0;
   int bad   = 0;
   logic [n_lp-1:0] sb_q[$];

   bsg_cgol_ctrl #(
      .board_width_p    (bw_lp),
      .max_game_length_p(max_lp)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .data_i      (data_i),
      .frames_i    (frames_i),
      .ready_o     (ready_o),
      .v_o         (v_o),
      .data_o      (data_o),
      .yumi_i      (yumi_i),
      .update_o    (update_o),
      .update_val_o(update_val_o),
      .en_o        (en_o),
      .cell_data_i (r_cells)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [n_lp-1:0] life_next(input logic [n_lp-1:0] b);
      logic [n_lp-1:0] nb;
      int nbrs;
      nb = '0;
      for (int r = 0; r < bw_lp; r++) begin
         for (int c = 0; c < bw_lp; c++) begin
            nbrs = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < bw_lp &&
                      c + dc >= 0 && c + dc < bw_lp) begin
                     nbrs += int'(b[(r + dr) * bw_lp + (c + dc)]);
                  end
               end
            end
            nb[r * bw_lp + c] = b[r * bw_lp + c] ? (nbrs == 2 || nbrs == 3) : (nbrs == 3);
         end
      end
      return nb;
   endfunction

   // Behavioral cell array
   always_ff @(posedge clk_i) begin
      if (reset_i)       r_cells <= '0;
      else if (update_o) r_cells <= update_val_o;
      else if (en_o)     r_cells <= life_next(r_cells);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One game: accept, track strobes to completion, score result, optional stall, consume
   task automatic play(input logic [n_lp-1:0] d, input int f, input int hold);
      int eff, n_en, n_upd, lat;
      logic [n_lp-1:0] exp_b, got_b, exp_sb;
      eff   = (f > int'(max_lp)) ? int'(max_lp) : f;
      exp_b = d;
      for (int i = 0; i < eff; i++) exp_b = life_next(exp_b);
      check_eq("ready_idle", 32'(ready_o), 32'd1);
      data_i   = d;
      frames_i = fw_lp'(f);
      v_i      = 1'b1;
      sb_q.push_back(exp_b);
      tick();
      v_i = 1'b0;
      check_eq("update_t1", 32'(update_o), 32'd1);
      check_eq("en_t1", 32'(en_o), 32'd0);
      check_eq("ready_load", 32'(ready_o), 32'd0);
      check_eq("update_val", 32'(update_val_o), 32'(d));
      n_en  = 0;
      n_upd = 0;
      tick();
      lat = 2;
      while (!v_o && lat < 1200) begin
         if (en_o) n_en++;
         if (update_o) n_upd++;
         if (ready_o) check_eq("ready_run", 32'(ready_o), 32'd0);
         tick();
         lat++;
      end
      check_eq("v_o_seen", 32'(v_o), 32'd1);
      check_eq("latency", 32'(lat), 32'(eff + 2));
      check_eq("en_count", 32'(n_en), 32'(eff));
      check_eq("extra_update", 32'(n_upd), 32'd0);
      check_eq("done_strobes", 32'({update_o, en_o, ready_o}), 32'd0);
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         exp_sb = sb_q.pop_front();
         check_eq("data_o", 32'(data_o), 32'(exp_sb));
      end
      got_b = data_o;
      v_i      = (hold > 0);
      data_i   = ~d;
      frames_i = fw_lp'(1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq("hold_v", 32'(v_o), 32'd1);
         check_eq("hold_data", 32'(data_o), 32'(got_b));
         check_eq("hold_ready", 32'(ready_o), 32'd0);
      end
      v_i    = 1'b0;
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      check_eq("idle_ready", 32'(ready_o), 32'd1);
      check_eq("idle_v", 32'(v_o), 32'd0);
   endtask

   initial begin
      tick();
      check_eq("rst_outs", 32'({ready_o, v_o, update_o, en_o}), 32'd0);
      tick();
      check_eq("rst_outs2", 32'({ready_o, v_o, update_o, en_o}), 32'd0);
      reset_i = 1'b0;
      #1;
      check_eq("post_rst_ready", 32'(ready_o), 32'd1);
      check_eq("post_rst_upd", 32'(update_val_o), 32'd0);

      play(16'h0070, 0, 0);
      play(16'h0070, 1, 0);
      play(16'h0070, 2, 0);
      play(16'h0070, 1, 0);
      play(16'h0070, 3, 10);

      // Abort mid-RUN with a one-cycle reset pulse
      data_i   = 16'h0070;
      frames_i = fw_lp'(5);
      v_i      = 1'b1;
      tick();
      v_i = 1'b0;
      tick();
      check_eq("abort_en_run", 32'(en_o), 32'd1);
      tick();
      reset_i = 1'b1;
      #1;
      check_eq("abort_in_rst", 32'({ready_o, v_o, update_o, en_o}), 32'd0);
      tick();
      check_eq("abort_after_edge", 32'({ready_o, v_o, update_o, en_o}), 32'd0);
      reset_i = 1'b0;
      #1;
      check_eq("abort_ready", 32'(ready_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("abort_quiet", 32'({v_o, en_o, update_o}), 32'd0);
      end

      play(16'h0070, 2000, 0);
      for (int k = 0; k < 3; k++) begin
         play(16'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bsg_cgol_ctrl.md
BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 Parameter board_width_p, default 8: board is board_width_p x board_width_p cells; N = board_width_p*board_width_p; cell index = row*board_width_p + col.
REQ-002 Parameter max_game_length_p, default 1024: maximum generations per game; frame width FW = $clog2(max_game_length_p+1).
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_i, input, 1: reset is synchronous and active-high.
REQ-005 Port v_i, input, 1: host request valid.
REQ-006 Port data_i, input, N: initial board; 1 = alive.
REQ-007 Port frames_i, input, FW: number of generations to simulate.
REQ-008 Port ready_o, output, 1: controller accepts a request.
REQ-009 Port v_o, output, 1: result board valid.
REQ-010 Port data_o, output, N: result board.
REQ-011 Port yumi_i, input, 1: host consumes the result; legal only while v_o=1.
REQ-012 Port update_o, output, 1: broadcast update_i to all cells.
REQ-013 Port update_val_o, output, N: per-cell update_val_i.
REQ-014 Port en_o, output, 1: broadcast compute enable en_i to all cells.
REQ-015 Port cell_data_i, input, N: current state of every cell (data_o of each cell).

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-017 IDLE: ready_o=1; on v_i&ready_o, SHALL register data_i into board_r and min(frames_i, max_game_length_p) into frame counter, then go to LOAD.
REQ-018 LOAD (exactly one cycle): update_o=1, update_val_o=board_r; next state RUN if counter!=0, else DONE.
REQ-019 RUN: en_o=1 every cycle; counter decrements by 1 per cycle; when counter==1, next state DONE.
REQ-020 en_o SHALL be asserted for exactly min(frames_i, max_game_length_p) cycles per game.
REQ-021 DONE: v_o=1, data_o=cell_data_i (combinational pass-through); on yumi_i go to IDLE.
REQ-022 update_o and en_o SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-023 update_val_o SHALL equal board_r in all states; only meaningful when update_o=1.
REQ-024 ready_o SHALL be 0 in LOAD, RUN, DONE; v_i in those states SHALL be ignored and not buffered.
REQ-025 v_o SHALL be 0 outside DONE; yumi_i outside DONE SHALL be ignored.
REQ-026 Latency: request accepted at cycle t -> update_o at t+1 -> en_o at t+2..t+1+F -> v_o from t+2+F (F = effective frame count).
REQ-027 Back-to-back: a new request MAY be accepted in the first IDLE cycle after yumi_i.

Reset
REQ-028 While reset_i=1, at the next edge: state=IDLE, counter=0, board_r=0.
REQ-029 While reset_i=1: ready_o=0, v_o=0, update_o=0, en_o=0.
REQ-030 Reset in any state (including mid-RUN) SHALL abort the game; no v_o for the aborted game; ready_o=1 in the first cycle after reset_i deasserts.

Verification
(bench: board_width_p=4, behavioral 4x4 cell array, dead boundary; blinker H=16'h0070, V=16'h0222)
REQ-031 frames_i=0, data_i=16'h0070 -> en_o never high; update_o high at t+1; v_o at t+2 with data_o=16'h0070.
REQ-032 frames_i=1, data_i=16'h0070 -> en_o high exactly 1 cycle (t+2); v_o at t+3, data_o=16'h0222.
REQ-033 frames_i=2, data_i=16'h0070 -> en_o high 2 cycles; data_o=16'h0070; then immediate second game frames_i=1 -> 16'h0222.
REQ-034 yumi_i held 0 for 10 cycles in DONE, v_i=1 throughout -> v_o stays 1, data_o stable, ready_o=0, no request accepted; yumi_i=1 -> IDLE next cycle.
REQ-035 reset_i pulsed for 1 cycle during RUN of frames_i=5 game -> en_o 0 from next cycle, no v_o, ready_o=1 after reset.
REQ-036 max_game_length_p=1024, frames_i=2000 -> en_o high exactly 1024 cycles, then v_o.
